// File: rtl/pe_array_pkg.sv
// Shared constants and control bundle for the element-wise MAC array.
package pe_array_pkg;

  localparam int ARRAY_DIM  = 16;
  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 32;
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  // Common strobes broadcast to every cell.
  typedef struct packed {
    logic acc_en;   // accumulate data * weight
    logic acc_clr;  // zero the accumulator (wins over acc_en)
    logic w_load;   // capture a new stationary weight
  } pe_ctrl_t;

endpackage

// File: rtl/pe_cell.sv
// One processing element: stationary weight, accumulator, multiply-add.
module pe_cell
  import pe_array_pkg::*;
#(
  parameter int DATA_WIDTH = pe_array_pkg::DATA_WIDTH,
  parameter int ACC_WIDTH  = pe_array_pkg::ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  pe_ctrl_t              ctrl,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] weight_in,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [DATA_WIDTH-1:0]   weight;
  logic [2*DATA_WIDTH-1:0] prod;

  // Unsigned product against the weight held before this edge.
  assign prod = data * weight;

  // Weight register: a load in the same cycle as a MAC only affects later MACs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           weight <= '0;
    else if (ctrl.w_load) weight <= weight_in;
  end

  // Accumulator: clear beats accumulate; the sum wraps modulo 2^ACC_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            acc <= '0;
    else if (ctrl.acc_clr) acc <= '0;
    else if (ctrl.acc_en)  acc <= acc + ACC_WIDTH'(prod);
  end

endmodule

// File: rtl/pe_array.sv
// ARRAY_DIM x ARRAY_DIM grid of independent MAC cells sharing control strobes.
module pe_array
  import pe_array_pkg::*;
#(
  parameter int ARRAY_DIM  = pe_array_pkg::ARRAY_DIM,
  parameter int DATA_WIDTH = pe_array_pkg::DATA_WIDTH,
  parameter int ACC_WIDTH  = pe_array_pkg::ACC_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         weight_write_enable,
  input  logic                                         acc_clear,
  input  logic                                         weight_load,
  input  logic [ARRAY_DIM*ARRAY_DIM*DATA_WIDTH-1:0]    data_in,
  input  logic [ARRAY_DIM*ARRAY_DIM*DATA_WIDTH-1:0]    weight_in,
  output logic [ARRAY_DIM*ARRAY_DIM*ACC_WIDTH-1:0]     acc_out
);

  pe_ctrl_t ctrl;

  // weight_write_enable is the compute strobe (legacy name), not a weight write.
  assign ctrl = '{acc_en: weight_write_enable, acc_clr: acc_clear, w_load: weight_load};

  for (genvar r = 0; r < ARRAY_DIM; r++) begin : g_row
    for (genvar c = 0; c < ARRAY_DIM; c++) begin : g_col
      localparam int IDX = r * ARRAY_DIM + c;
      pe_cell #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk      (clk),
        .rst_n    (rst_n),
        .ctrl     (ctrl),
        .data     (data_in  [IDX*DATA_WIDTH +: DATA_WIDTH]),
        .weight_in(weight_in[IDX*DATA_WIDTH +: DATA_WIDTH]),
        .acc      (acc_out  [IDX*ACC_WIDTH  +: ACC_WIDTH])
      );
    end
  end

endmodule

// File: tb/tb_pe_array.sv
// Directed bench for pe_array with an element-wise array model checked every cycle.
module tb_pe_array;

  localparam int N  = 16;
  localparam int NP = N * N;
  localparam int DW = 8;
  localparam int AW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 weight_write_enable = 1'b0;
  logic                 acc_clear = 1'b0;
  logic                 weight_load = 1'b0;
  logic [NP*DW-1:0]     data_in = '0;
  logic [NP*DW-1:0]     weight_in = '0;
  logic [NP*AW-1:0]     acc_out;

  pe_array dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .weight_write_enable(weight_write_enable),
    .acc_clear          (acc_clear),
    .weight_load        (weight_load),
    .data_in            (data_in),
    .weight_in          (weight_in),
    .acc_out            (acc_out)
  );

  always #5 clk = ~clk;

  // Model state: one weight and one accumulator per PE.
  int unsigned wm[NP];
  int unsigned am[NP];
  int unsigned d_v[NP];
  int unsigned w_v[NP];

  int passed = 0;
  int total  = 0;

  function automatic int pidx(int r, int c);
    return r * N + c;
  endfunction

  task automatic drive_buses();
    for (int i = 0; i < NP; i++) begin
      data_in  [i*DW +: DW] = d_v[i][DW-1:0];
      weight_in[i*DW +: DW] = w_v[i][DW-1:0];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      wm[i] = 0;
      am[i] = 0;
    end
  endtask

  // Compare every PE against the model; one comparison per call.
  task automatic check_all(string name);
    int bad;
    logic [AW-1:0] got;
    bad = -1;
    for (int i = 0; i < NP; i++) begin
      got = acc_out[i*AW +: AW];
      if (bad < 0 && got !== am[i]) bad = i;
    end
    total++;
    if (bad < 0) passed++;
    else $display("FAIL %s pe(%0d,%0d) got %0d expected %0d", name, bad / N, bad % N,
                  acc_out[bad*AW +: AW], am[bad]);
  endtask

  // Hand-computed literal expectation on one PE.
  task automatic check_lit(string name, int r, int c, int unsigned exp);
    logic [AW-1:0] got;
    got = acc_out[pidx(r, c)*AW +: AW];
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s pe(%0d,%0d) got %0d expected %0d", name, r, c, got, exp);
  endtask

  // One clock: model follows the edge, then outputs are checked at the falling edge.
  task automatic step(string name);
    drive_buses();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      for (int i = 0; i < NP; i++) begin
        if (acc_clear) am[i] = 0;
        else if (weight_write_enable) am[i] = am[i] + d_v[i] * wm[i];
        if (weight_load) wm[i] = w_v[i];
      end
    end
    @(negedge clk);
    check_all(name);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NP; i++) begin
      d_v[i] = 0;
      w_v[i] = 0;
    end

    // Reset held.
    repeat (3) step("reset");
    check_lit("reset_00", 0, 0, 0);
    check_lit("reset_ff", 15, 15, 0);
    rst_n = 1'b1;

    // Load weight = r+1, then one MAC with data = c+1.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) w_v[pidx(r, c)] = r + 1;
    weight_load = 1'b1;
    step("load");
    check_lit("load_no_mac", 2, 3, 0);
    weight_load = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) d_v[pidx(r, c)] = c + 1;
    weight_write_enable = 1'b1;
    step("mac1");
    check_lit("mac1_23", 2, 3, 12);
    check_lit("mac1_ff", 15, 15, 256);

    // Second MAC with data = r+c.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) d_v[pidx(r, c)] = r + c;
    step("mac2");
    check_lit("mac2_23", 2, 3, 27);
    check_lit("mac2_ff", 15, 15, 736);

    // Idle holds.
    weight_write_enable = 1'b0;
    step("idle");
    check_lit("idle_23", 2, 3, 27);

    // Clear.
    acc_clear = 1'b1;
    step("clear");
    check_lit("clear_55", 5, 5, 0);
    acc_clear = 1'b0;

    // Clear together with enable: clear wins.
    for (int i = 0; i < NP; i++) d_v[i] = 9;
    weight_write_enable = 1'b1;
    step("pre_clr_en");
    check_lit("pre_clr_en_23", 2, 3, 27);
    acc_clear = 1'b1;
    step("clr_en");
    check_lit("clr_en_23", 2, 3, 0);
    acc_clear = 1'b0;

    // Load with enable: MAC uses old weight (r+1), next MAC uses 7.
    for (int i = 0; i < NP; i++) begin
      d_v[i] = 2;
      w_v[i] = 7;
    end
    weight_load = 1'b1;
    step("load_mac");
    check_lit("load_mac_23", 2, 3, 6);
    weight_load = 1'b0;
    for (int i = 0; i < NP; i++) d_v[i] = 1;
    step("after_load");
    check_lit("after_load_23", 2, 3, 13);
    weight_write_enable = 1'b0;

    // Async reset between edges.
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    check_lit("async_rst_23", 2, 3, 0);
    step("rst_hold");
    rst_n = 1'b1;

    // Extremes: 255 * 255 repeatedly, wrapping modulo 2^32.
    for (int i = 0; i < NP; i++) begin
      w_v[i] = 255;
      d_v[i] = 255;
    end
    weight_load = 1'b1;
    step("load_max");
    weight_load = 1'b0;
    weight_write_enable = 1'b1;
    for (int k = 0; k < 66052; k++) begin
      step("wrap");
      if (k == 0) check_lit("max_first", 7, 9, 65025);
      if (k == 1) check_lit("max_second", 7, 9, 130050);
    end
    check_lit("wrap_00", 0, 0, 64004);
    check_lit("wrap_79", 7, 9, 64004);
    weight_write_enable = 1'b0;
    step("wrap_hold");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pe_array.md
Name: pe_array

Overview:
- 2-D grid of ARRAY_DIM x ARRAY_DIM independent multiply-accumulate processing elements (PEs).
- Each PE holds its own stationary weight and 32-bit accumulator, and receives its own data operand.
- No inter-PE data movement; the array is a fully parallel element-wise MAC engine feeding downstream reduction/readout logic.
- All PEs share one clock and common control strobes.

Parameters:
- ARRAY_DIM, 16, rows = columns of the PE grid.
- DATA_WIDTH, 8, width of each data and weight operand (unsigned).
- ACC_WIDTH, 32, width of each accumulator.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- weight_write_enable  in  1  compute strobe: while high, every PE accumulates data x weight. The name is historical; it does not write weights.
- acc_clear  in  1  synchronous clear of all accumulators.
- weight_load  in  1  synchronous capture of weight_in into all weight registers.
- data_in  in  ARRAY_DIM*ARRAY_DIM*DATA_WIDTH  per-PE data; PE(r,c) at bits [(r*ARRAY_DIM+c)*DATA_WIDTH +: DATA_WIDTH].
- weight_in  in  ARRAY_DIM*ARRAY_DIM*DATA_WIDTH  per-PE weight, same packing as data_in.
- acc_out  out  ARRAY_DIM*ARRAY_DIM*ACC_WIDTH  per-PE accumulator; PE(r,c) at bits [(r*ARRAY_DIM+c)*ACC_WIDTH +: ACC_WIDTH].

Behaviour:
- Reset: rst_n low asynchronously forces every weight register and every accumulator to 0, so acc_out = 0. Reset asserted mid-operation discards all state immediately.
- Weight load:
  - On a rising edge with weight_load = 1, weight(r,c) <= weight_in slice(r,c).
  - The weight holds its value until the next load or reset.
- Accumulate:
  - On a rising edge with weight_write_enable = 1 and acc_clear = 0, acc(r,c) <= acc(r,c) + data(r,c) * weight(r,c).
  - weight(r,c) is the registered weight value before that edge.
- Clear: on a rising edge with acc_clear = 1, acc(r,c) <= 0. Clear has priority over accumulate in the same cycle.
- Idle: when neither accumulate nor clear is active, the accumulator holds its value.
- Weight load and accumulate in the same cycle:
  - The accumulate uses the old weight.
  - The new weight takes effect from the next cycle.
- Arithmetic:
  - Operands are unsigned.
  - The 2*DATA_WIDTH product is zero-extended to ACC_WIDTH.
  - The sum wraps modulo 2^ACC_WIDTH, with no saturation or overflow flag.
- Latency: acc_out is the accumulator register directly. A result is visible one clock edge after the enabling edge, with no combinational path from inputs to acc_out.
- Independence: all PEs update simultaneously; no PE depends on any other PE.

Decomposition:
- Shared package pe_array_pkg holds the default constants DATA_WIDTH, ACC_WIDTH and ARRAY_DIM, plus a localparam for product width (2*DATA_WIDTH).
- One natural sub-module, pe_cell:
  - Contains one weight register, one accumulator and one multiplier-adder.
  - pe_array instantiates it ARRAY_DIM^2 times with a generate loop and does the bus slicing.

Test Plan:
- Reset check: hold rst_n = 0, then release -> every acc_out slice = 0.
- Load and single MAC:
  - Stimulus: load weight(r,c) = r+1, set data(r,c) = c+1, one-cycle enable.
  - Response: acc(r,c) = (r+1)*(c+1) for all 256 PEs; for example PE(2,3) = 12.
- Second accumulate: keep weights, set data(r,c) = r+c, one-cycle enable -> PE(2,3) = 12 + 3*5 = 27, and every PE equals its previous value plus (r+1)*(r+c).
- Clear: pulse acc_clear for one cycle -> all acc = 0; for example PE(5,5) = 0.
- Priority and hazards:
  - acc_clear together with enable -> acc = 0.
  - weight_load together with enable -> MAC uses the old weight, and the next MAC uses the new weight.
- Extremes and async reset:
  - weight = data = 255, accumulated repeatedly -> increments of 65025 with modulo-2^32 wrap.
  - Assert rst_n between clock edges -> acc_out goes to 0 before the next edge.
